id_fetch_ctrl: RTL and testbench

ID_FETCH_CTRL -- requirements
Module: id_fetch_ctrl

---
 rtl/id_fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_id_fetch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/id_fetch_ctrl.sv
// rtl/id_fetch_ctrl.sv - IF/ID register with hazard freeze, branch flush and event counters.
// Optional macro ID_FETCH_FORWARDING_EN: non-branch hazards reduce to load-use only.
module id_fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instruction,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [4:0]  ex_dest,
  input  logic        ex_wb_en,
  input  logic        ex_mem_read,
  input  logic [4:0]  mem_dest,
  input  logic        mem_wb_en,
  output logic        freez,
  output logic        br_taken,
  output logic [31:0] br_offset,
  output logic [31:0] id_pc,
  output logic [31:0] id_instruction,
  output logic        id_valid,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic        is_beq;
  logic        is_bne;
  logic        is_branch;
  logic        uses_rt;
  logic        src_ex;
  logic        src_mem;
  logic        wb_hazard;
  logic        load_use;
  logic        data_hazard;
  logic        hazard;
  logic        br_cond;
  logic        hold_ifid;
  logic        bubble_ifid;

  assign opcode = id_instruction[31:26];
  assign rs     = id_instruction[25:21];
  assign rt     = id_instruction[20:16];
  assign imm    = id_instruction[15:0];

  assign is_beq    = (opcode == OP_BEQ);
  assign is_bne    = (opcode == OP_BNE);
  assign is_branch = is_beq | is_bne;
  assign uses_rt   = (opcode == OP_RTYPE) | is_beq | is_bne | (opcode == OP_SW);

  // Register 0 is hardwired, so it never creates a dependency.
  assign src_ex  = ((rs != 5'd0) && (rs == ex_dest)) ||
                   (uses_rt && (rt != 5'd0) && (rt == ex_dest));
  assign src_mem = ((rs != 5'd0) && (rs == mem_dest)) ||
                   (uses_rt && (rt != 5'd0) && (rt == mem_dest));

  assign wb_hazard = (src_ex & ex_wb_en) | (src_mem & mem_wb_en);
  assign load_use  = src_ex & ex_mem_read;

`ifdef ID_FETCH_FORWARDING_EN
  assign data_hazard = load_use;
`else
  assign data_hazard = wb_hazard | load_use;
`endif

  // Branches compare raw register-file values in ID, so they cannot use forwarding.
  assign hazard = data_hazard | (is_branch & (wb_hazard | load_use));

  assign freez     = id_valid & hazard;
  assign br_cond   = (is_beq & (rs_val == rt_val)) | (is_bne & (rs_val != rt_val));
  assign br_taken  = id_valid & ~freez & br_cond;
  assign br_offset = id_valid ? {{16{imm[15]}}, imm} : 32'd0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = RUN;
    if (freez) begin
      state_next = STALL;
    end else if (br_taken) begin
      state_next = FLUSH;
    end
  end

  always_comb begin
    hold_ifid   = 1'b0;
    bubble_ifid = 1'b0;
    case (state_next)
      STALL:   hold_ifid   = 1'b1;
      FLUSH:   bubble_ifid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_pc          <= 32'd0;
      id_instruction <= 32'd0;
      id_valid       <= 1'b0;
      stall_cnt      <= 16'd0;
      flush_cnt      <= 16'd0;
    end else begin
      if (hold_ifid) begin
        if (stall_cnt != 16'hFFFF) begin
          stall_cnt <= stall_cnt + 16'd1;
        end
      end else if (bubble_ifid) begin
        // All-zero instruction decodes as an R-type nop on r0: no branch, no hazard.
        id_pc          <= if_pc;
        id_instruction <= 32'd0;
        id_valid       <= 1'b0;
        if (flush_cnt != 16'hFFFF) begin
          flush_cnt <= flush_cnt + 16'd1;
        end
      end else begin
        id_pc          <= if_pc;
        id_instruction <= if_instruction;
        id_valid       <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && (state == FLUSH)) begin
      assert (!id_valid) else $error("IF/ID not a bubble after flush");
    end
  end

endmodule

// File: tb/tb_id_fetch_ctrl.sv
// tb/tb_id_fetch_ctrl.sv - table-driven scoreboard bench for id_fetch_ctrl.
module tb_id_fetch_ctrl;

`ifdef ID_FETCH_FORWARDING_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif
  localparam logic NF = ~FWD;

  localparam logic [31:0] I_ADD  = 32'h00642820;
  localparam logic [31:0] I_LW   = 32'h8D280004;
  localparam logic [31:0] I_BEQ  = 32'h1022FFFE;
  localparam logic [31:0] I_BNE  = 32'h14C70010;
  localparam logic [31:0] I_SW   = 32'hAD280004;
  localparam logic [31:0] I_ZADD = 32'h00000820;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_instruction, rs_val, rt_val;
  logic [4:0]  ex_dest, mem_dest;
  logic        ex_wb_en, ex_mem_read, mem_wb_en;
  logic        freez, br_taken, id_valid;
  logic [31:0] br_offset, id_pc, id_instruction;
  logic [15:0] stall_cnt, flush_cnt;

  id_fetch_ctrl dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instruction(if_instruction),
    .rs_val(rs_val), .rt_val(rt_val), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
    .ex_mem_read(ex_mem_read), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .freez(freez), .br_taken(br_taken), .br_offset(br_offset), .id_pc(id_pc),
    .id_instruction(id_instruction), .id_valid(id_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, ins, rsv, rtv;
    logic [4:0]  exd;
    logic        exw, exr;
    logic [4:0]  md;
    logic        mw;
    logic        ef, eb;
    logic [31:0] eo;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc, ins;
    logic        valid;
    logic [15:0] stall, flush;
    logic [1:0]  state;
  } exp_t;

  vec_t vecs[17];
  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc, m_ins;
  logic        m_valid;
  logic [15:0] m_stall, m_flush;

  function automatic vec_t mk(input logic [31:0] pc, ins, rsv, rtv,
                              input logic [4:0] exd, input logic exw, exr,
                              input logic [4:0] md, input logic mw,
                              input logic ef, eb, input logic [31:0] eo);
    vec_t v;
    v.pc = pc; v.ins = ins; v.rsv = rsv; v.rtv = rtv;
    v.exd = exd; v.exw = exw; v.exr = exr; v.md = md; v.mw = mw;
    v.ef = ef; v.eb = eb; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_pc = v.pc; if_instruction = v.ins; rs_val = v.rsv; rt_val = v.rtv;
    ex_dest = v.exd; ex_wb_en = v.exw; ex_mem_read = v.exr;
    mem_dest = v.md; mem_wb_en = v.mw;
  endtask

  task automatic check_regs(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
      return;
    end
    e = sbq.pop_front();
    chk($sformatf("%s/v%0d id_pc", tag, e.idx), id_pc, e.pc);
    chk($sformatf("%s/v%0d id_instruction", tag, e.idx), id_instruction, e.ins);
    chk($sformatf("%s/v%0d id_valid", tag, e.idx), {31'd0, id_valid}, {31'd0, e.valid});
    chk($sformatf("%s/v%0d stall_cnt", tag, e.idx), {16'd0, stall_cnt}, {16'd0, e.stall});
    chk($sformatf("%s/v%0d flush_cnt", tag, e.idx), {16'd0, flush_cnt}, {16'd0, e.flush});
    chk($sformatf("%s/v%0d state", tag, e.idx), {30'd0, dut.state}, {30'd0, e.state});
  endtask

  // One clock with vector v: combinational checks at negedge, register checks after the edge.
  task automatic cycle(input string tag, input int idx, input vec_t v);
    exp_t e;
    drive(v);
    @(negedge clk);
    chk($sformatf("%s/v%0d freez", tag, idx), {31'd0, freez}, {31'd0, v.ef});
    chk($sformatf("%s/v%0d br_taken", tag, idx), {31'd0, br_taken}, {31'd0, v.eb});
    chk($sformatf("%s/v%0d br_offset", tag, idx), br_offset, v.eo);
    if (v.ef) begin
      if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      e.state = S_STALL;
    end else if (v.eb) begin
      m_pc = v.pc; m_ins = 32'd0; m_valid = 1'b0;
      if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
      e.state = S_FLUSH;
    end else begin
      m_pc = v.pc; m_ins = v.ins; m_valid = 1'b1;
      e.state = S_RUN;
    end
    e.idx = idx; e.pc = m_pc; e.ins = m_ins; e.valid = m_valid;
    e.stall = m_stall; e.flush = m_flush;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " freez"}, {31'd0, freez}, 32'd0);
    chk({tag, " br_taken"}, {31'd0, br_taken}, 32'd0);
    chk({tag, " br_offset"}, br_offset, 32'd0);
    chk({tag, " id_pc"}, id_pc, 32'd0);
    chk({tag, " id_instruction"}, id_instruction, 32'd0);
    chk({tag, " id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, " stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
    chk({tag, " flush_cnt"}, {16'd0, flush_cnt}, 32'd0);
    chk({tag, " state"}, {30'd0, dut.state}, {30'd0, S_RUN});
  endtask

  initial begin
    vec_t hz;
    vecs[0]  = mk(32'h04, I_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(32'h08, I_ADD, 0, 0, 3, 1, 1, 0, 0, 1, 0, 32'h2820);
    vecs[2]  = mk(32'h08, I_ADD, 0, 0, 3, 1, 0, 0, 0, NF, 0, 32'h2820);
    vecs[3]  = mk(32'h0C, I_BEQ, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2820);
    vecs[4]  = mk(32'h10, I_LW, 7, 7, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFE);
    vecs[5]  = mk(32'h14, I_BEQ, 1, 2, 0, 1, 1, 0, 1, 0, 0, 32'h0);
    vecs[6]  = mk(32'h18, I_BNE, 1, 2, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFE);
    vecs[7]  = mk(32'h1C, I_SW, 1, 2, 0, 0, 0, 6, 1, 1, 0, 32'h10);
    vecs[8]  = mk(32'h1C, I_SW, 1, 2, 0, 0, 0, 6, 0, 0, 1, 32'h10);
    vecs[9]  = mk(32'h20, I_SW, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vecs[10] = mk(32'h24, I_SW, 0, 0, 8, 1, 1, 0, 0, 1, 0, 32'h4);
    vecs[11] = mk(32'h24, I_SW, 0, 0, 8, 0, 0, 9, 1, NF, 0, 32'h4);
    vecs[12] = mk(32'h28, I_LW, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4);
    vecs[13] = mk(32'h2C, I_ZADD, 0, 0, 8, 1, 1, 0, 0, 0, 0, 32'h4);
    vecs[14] = mk(32'h30, I_BEQ, 0, 0, 0, 1, 1, 0, 1, 0, 0, 32'h820);
    vecs[15] = mk(32'h34, I_LW, 5, 5, 2, 1, 0, 0, 0, 1, 0, 32'hFFFFFFFE);
    vecs[16] = mk(32'h34, I_LW, 5, 5, 2, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFE);

    // Reset held for two edges with busy inputs.
    rst = 1'b0;
    drive(vecs[1]);
    @(posedge clk); #1;
    check_reset_state("reset1");
    @(posedge clk); #1;
    check_reset_state("reset2");
    m_pc = 0; m_ins = 0; m_valid = 0; m_stall = 0; m_flush = 0;
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cycle("tbl", i, vecs[i]);
    end

    // Freeze long enough to saturate stall_cnt, then reset mid-stall.
    cycle("sat_load", 100, mk(32'h40, I_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    hz = mk(32'h44, I_LW, 0, 0, 3, 1, 1, 0, 0, 1, 0, 32'h2820);
    drive(hz);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat stall_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat freez", {31'd0, freez}, 32'd1);
    chk("sat id_pc held", id_pc, 32'h40);
    chk("sat flush_cnt", {16'd0, flush_cnt}, {16'd0, m_flush});
    m_stall = 16'hFFFF;
    cycle("sat_more", 101, hz);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_state("mid_stall_reset");
    rst = 1'b1;
    m_pc = 0; m_ins = 0; m_valid = 0; m_stall = 0; m_flush = 0;
    cycle("post_reset", 102, mk(32'h04, I_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));

    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
